// File: rtl/conv1d_mac_acc.sv
// Multiply-accumulate stage of the conv1d core: bias plus n_taps signed x*w
// products, result presented on a valid/ready handshake.
module conv1d_mac_acc #(
  parameter int n_bit   = 8,
  parameter int n_taps  = 3,
  parameter int acc_bit = 18
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic signed [acc_bit-1:0] bias,
  input  logic signed [n_bit-1:0]   x_in,
  input  logic signed [n_bit-1:0]   w_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic signed [acc_bit-1:0] y_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy
);

  localparam int CNT_W = (n_taps > 1) ? $clog2(n_taps) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(n_taps - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                r_state;
  logic signed [acc_bit-1:0] r_acc;
  logic [CNT_W-1:0]          r_tap_cnt;
  logic signed [acc_bit-1:0] r_y_out;
  logic                      r_in_ready;
  logic                      r_out_valid;
  logic                      r_busy;

  logic [1:0]                w_state_nxt;
  logic signed [acc_bit-1:0] w_acc_nxt;
  logic [CNT_W-1:0]          w_tap_cnt_nxt;
  logic signed [acc_bit-1:0] w_y_out_nxt;
  logic signed [2*n_bit-1:0] w_prod;
  logic signed [acc_bit-1:0] w_prod_ext;
  logic signed [acc_bit-1:0] w_sum;

  // Full-width signed product, sign-extended; the sum wraps modulo 2^acc_bit
  always_comb begin
    w_prod     = x_in * w_in;
    w_prod_ext = acc_bit'(w_prod);
    w_sum      = r_acc + w_prod_ext;
  end

  // Next-state and datapath decode
  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_tap_cnt_nxt = r_tap_cnt;
    w_y_out_nxt   = r_y_out;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_acc_nxt     = bias;
          w_tap_cnt_nxt = '0;
          w_state_nxt   = S_ACC;
        end else begin
          w_state_nxt   = S_IDLE;
        end
      end
      S_ACC: begin
        if (in_valid && r_in_ready) begin
          w_acc_nxt     = w_sum;
          w_tap_cnt_nxt = r_tap_cnt + CNT_W'(1);
          if (r_tap_cnt == LAST_TAP) begin
            w_y_out_nxt = w_sum;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_ACC;
          end
        end else begin
          w_state_nxt = S_ACC;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, datapath and handshake flags; flags decode the next state so they are registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_tap_cnt   <= '0;
      r_y_out     <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_tap_cnt   <= w_tap_cnt_nxt;
      r_y_out     <= w_y_out_nxt;
      r_in_ready  <= (w_state_nxt == S_ACC);
      r_out_valid <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign y_out     = r_y_out;

endmodule

// File: tb/tb_conv1d_mac_acc.sv
// Directed self-checking bench for conv1d_mac_acc (n_bit=8, n_taps=3, acc_bit=18).
module tb_conv1d_mac_acc;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic signed [17:0] bias;
  logic signed [7:0]  x_in;
  logic signed [7:0]  w_in;
  logic               in_valid;
  logic               in_ready;
  logic signed [17:0] y_out;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  int checks = 0;
  int errors = 0;

  conv1d_mac_acc #(.n_bit(8), .n_taps(3), .acc_bit(18)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
    .x_in(x_in), .w_in(w_in), .in_valid(in_valid), .in_ready(in_ready),
    .y_out(y_out), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_y"}, y_out, 0);
    chk({tag, "_ov"}, out_valid, 0);
    chk({tag, "_ir"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_start(input int b);
    start = 1'b1;
    bias  = 18'(b);
    tick();
    start = 1'b0;
    bias  = 18'sd0;
  endtask

  task automatic send_tap(input int x, input int w, input int gap);
    in_valid = 1'b1;
    x_in     = 8'(x);
    w_in     = 8'(w);
    tick();
    in_valid = 1'b0;
    x_in     = 8'sd0;
    w_in     = 8'sd0;
    repeat (gap) tick();
  endtask

  task automatic finish_hs(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ov_drop"}, out_valid, 0);
    chk({tag, "_busy_drop"}, busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; bias = 18'sd0; x_in = 8'sd0; w_in = 8'sd0;
    in_valid = 1'b0; out_ready = 1'b0;

    // reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom); bias = 18'($urandom); x_in = 8'($urandom);
      w_in = 8'($urandom); in_valid = 1'($urandom); out_ready = 1'($urandom);
      tick();
    end
    chk_idle_zero("rst");
    rst_n = 1'b1; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom); x_in = 8'($urandom); w_in = 8'($urandom);
      out_ready = 1'($urandom);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk_idle_zero("post_rst");

    // basic: 10 + 6 - 4 - 10 = 2, out_valid on the 4th edge from start
    do_start(10);
    chk("basic_ir", in_ready, 1);
    chk("basic_busy", busy, 1);
    send_tap(2, 3, 0);
    send_tap(4, -1, 0);
    chk("basic_ov_early", out_valid, 0);
    send_tap(-5, 2, 0);
    chk("basic_ov", out_valid, 1);
    chk("basic_ir_done", in_ready, 0);
    chk("basic_y", y_out, 2);
    finish_hs("basic");

    // stalls between taps and downstream backpressure
    do_start(10);
    send_tap(2, 3, 3);
    send_tap(4, -1, 3);
    chk("stall_ov_early", out_valid, 0);
    chk("stall_ir", in_ready, 1);
    send_tap(-5, 2, 0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold_ov", out_valid, 1);
      chk("stall_hold_y", y_out, 2);
      tick();
    end
    chk("stall_y_final", y_out, 2);
    finish_hs("stall");

    // extremes; start immediately after returning to IDLE
    do_start(0);
    chk("ext1_busy", busy, 1);
    for (int i = 0; i < 3; i++) send_tap(-128, -128, 0);
    chk("ext1_y", y_out, 49152);
    finish_hs("ext1");
    do_start(0);
    for (int i = 0; i < 3; i++) send_tap(-128, 127, 0);
    chk("ext2_y", y_out, -48768);
    finish_hs("ext2");

    // ignored controls: in_valid in IDLE, start in ACC and DONE
    in_valid = 1'b1; x_in = 8'sd100; w_in = 8'sd100;
    tick(); tick();
    in_valid = 1'b0;
    chk("ign_idle_busy", busy, 0);
    chk("ign_idle_ir", in_ready, 0);
    do_start(7);
    send_tap(1, 2, 0);
    start = 1'b1; bias = 18'sd999;
    tick();
    start = 1'b0; bias = 18'sd0;
    chk("ign_acc_ir", in_ready, 1);
    send_tap(3, 4, 0);
    send_tap(5, 6, 0);
    chk("ign_y", y_out, 51);
    start = 1'b1; bias = 18'sd500;
    tick(); tick();
    start = 1'b0;
    chk("ign_done_ov", out_valid, 1);
    chk("ign_done_y", y_out, 51);
    finish_hs("ign");
    tick();
    chk("ign_after_busy", busy, 0);

    // abort after 2 of 3 taps, then a fresh computation
    do_start(100);
    send_tap(9, 9, 0);
    send_tap(9, 9, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_idle_zero("abort");
    tick();
    rst_n = 1'b1;
    tick();
    chk_idle_zero("abort_rel");
    do_start(0);
    for (int i = 0; i < 3; i++) send_tap(1, 1, 0);
    chk("abort_next_ov", out_valid, 1);
    chk("abort_next_y", y_out, 3);
    finish_hs("abort_next");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
